// File: rtl/ub_pkg.sv
// Shared defaults and address-width helpers for the banked unified buffer.
package ub_pkg;
  localparam int ELEM_WIDTH_DEF = 8;
  localparam int SA_LENGTH_DEF  = 256;

  function automatic int host_addr_w(input int addr_w, input int no_banks, input int sa_len);
    return addr_w + $clog2(no_banks) + $clog2(sa_len);
  endfunction

  function automatic int array_addr_w(input int addr_w, input int no_banks);
    return addr_w + $clog2(no_banks);
  endfunction

  typedef logic [SA_LENGTH_DEF-1:0][ELEM_WIDTH_DEF-1:0] lane_vec_t;
endpackage

// File: rtl/banked_unified_buffer_if.sv
// Host (narrow) and array (wide) request ports of the banked unified buffer.
interface banked_unified_buffer_if #(
  parameter int SA_LENGTH  = 256,
  parameter int ELEM_WIDTH = ub_pkg::ELEM_WIDTH_DEF,
  parameter int ADDR_WIDTH = 10,
  parameter int NO_BANKS   = 8
);
  localparam int HAW = ub_pkg::host_addr_w(ADDR_WIDTH, NO_BANKS, SA_LENGTH);
  localparam int AAW = ub_pkg::array_addr_w(ADDR_WIDTH, NO_BANKS);

  // Handshake: a request is accepted in a cycle where req and gnt are both high;
  // until then the requester holds req and its fields stable. A read returns
  // with rvalid exactly two enabled cycles after acceptance; rdata holds otherwise.
  logic                                 h_req;
  logic                                 h_we;
  logic [HAW-1:0]                       h_addr;
  logic [ELEM_WIDTH-1:0]                h_wdata;
  logic [ELEM_WIDTH-1:0]                h_rdata;
  logic                                 h_gnt;
  logic                                 h_rvalid;
  logic                                 a_req;
  logic                                 a_we;
  logic [AAW-1:0]                       a_addr;
  logic [SA_LENGTH-1:0]                 a_wmask;
  logic [SA_LENGTH-1:0][ELEM_WIDTH-1:0] a_wdata;
  logic [SA_LENGTH-1:0][ELEM_WIDTH-1:0] a_rdata;
  logic                                 a_gnt;
  logic                                 a_rvalid;
  logic [15:0]                          conflict_cnt;

  modport master (
    output h_req, h_we, h_addr, h_wdata, a_req, a_we, a_addr, a_wmask, a_wdata,
    input  h_rdata, h_gnt, h_rvalid, a_rdata, a_gnt, a_rvalid, conflict_cnt
  );
  modport slave (
    input  h_req, h_we, h_addr, h_wdata, a_req, a_we, a_addr, a_wmask, a_wdata,
    output h_rdata, h_gnt, h_rvalid, a_rdata, a_gnt, a_rvalid, conflict_cnt
  );
endinterface

// File: rtl/ub_bank.sv
// One single-port bank: per-lane write enable, registered wide read.
module ub_bank
  import ub_pkg::*;
#(
  parameter int SA_LENGTH  = 256,
  parameter int ELEM_WIDTH = ELEM_WIDTH_DEF,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                                 i_clk,
  input  logic                                 i_cs,
  input  logic                                 i_we,
  input  logic [ADDR_WIDTH-1:0]                i_addr,
  input  logic [SA_LENGTH-1:0]                 i_wmask,
  input  logic [SA_LENGTH-1:0][ELEM_WIDTH-1:0] i_wdata,
  output logic [SA_LENGTH-1:0][ELEM_WIDTH-1:0] o_rdata
);
  logic [SA_LENGTH-1:0][ELEM_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [SA_LENGTH-1:0][ELEM_WIDTH-1:0] r_rdata;

  // Contents are never reset; the read register only changes on a read.
  always_ff @(posedge i_clk) begin
    if (i_cs) begin
      if (i_we) begin
        for (int i = 0; i < SA_LENGTH; i++) begin
          if (i_wmask[i]) r_mem[i_addr][i] <= i_wdata[i];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/banked_unified_buffer.sv
// Banked buffer shared by a narrow host port and a wide array port; the array always wins a bank.
module banked_unified_buffer
  import ub_pkg::*;
#(
  parameter int SA_LENGTH  = 256,
  parameter int ELEM_WIDTH = ELEM_WIDTH_DEF,
  parameter int ADDR_WIDTH = 10,
  parameter int NO_BANKS   = 8
) (
  input  logic CLK,
  input  logic ASYNC_RST,
  input  logic SYNC_RST,
  input  logic EN,
  banked_unified_buffer_if.slave bus
);
  localparam int BANK_BITS = $clog2(NO_BANKS);
  localparam int LANE_BITS = $clog2(SA_LENGTH);
  typedef logic [SA_LENGTH-1:0][ELEM_WIDTH-1:0] vec_t;

  logic                  w_a_gnt, w_h_gnt, w_same_bank, w_a_go, w_h_go;
  logic [BANK_BITS-1:0]  w_a_bank, w_h_bank;
  logic [ADDR_WIDTH-1:0] w_a_word, w_h_word;
  logic [LANE_BITS-1:0]  w_h_lane;

  assign w_a_bank    = bus.a_addr[BANK_BITS-1:0];
  assign w_a_word    = bus.a_addr[BANK_BITS +: ADDR_WIDTH];
  assign w_h_lane    = bus.h_addr[LANE_BITS-1:0];
  assign w_h_bank    = bus.h_addr[LANE_BITS +: BANK_BITS];
  assign w_h_word    = bus.h_addr[LANE_BITS+BANK_BITS +: ADDR_WIDTH];
  assign w_a_gnt     = EN & ~SYNC_RST & ~ASYNC_RST;
  assign w_same_bank = (w_a_bank == w_h_bank);
  assign w_h_gnt     = w_a_gnt & ~(bus.a_req & w_same_bank);
  assign w_a_go      = bus.a_req & w_a_gnt;
  assign w_h_go      = bus.h_req & w_h_gnt;

  logic                  w_cs    [NO_BANKS];
  logic                  w_we    [NO_BANKS];
  logic [ADDR_WIDTH-1:0] w_addr  [NO_BANKS];
  logic [SA_LENGTH-1:0]  w_wmask [NO_BANKS];
  vec_t                  w_wdata [NO_BANKS];
  vec_t                  w_rdata [NO_BANKS];

  // Host and array never share a bank in one cycle, so each bank sees at most one.
  always_comb begin
    for (int b = 0; b < NO_BANKS; b++) begin
      w_cs[b]    = 1'b0;
      w_we[b]    = 1'b0;
      w_addr[b]  = '0;
      w_wmask[b] = '0;
      w_wdata[b] = '0;
      if (w_a_go && (w_a_bank == BANK_BITS'(b))) begin
        w_cs[b]    = 1'b1;
        w_we[b]    = bus.a_we;
        w_addr[b]  = w_a_word;
        w_wmask[b] = bus.a_wmask;
        w_wdata[b] = bus.a_wdata;
      end else if (w_h_go && (w_h_bank == BANK_BITS'(b))) begin
        w_cs[b]    = 1'b1;
        w_we[b]    = bus.h_we;
        w_addr[b]  = w_h_word;
        w_wmask[b] = SA_LENGTH'(1) << w_h_lane;
        w_wdata[b] = {SA_LENGTH{bus.h_wdata}};
      end
    end
  end

  for (genvar g = 0; g < NO_BANKS; g++) begin : g_bank
    ub_bank #(
      .SA_LENGTH (SA_LENGTH),
      .ELEM_WIDTH(ELEM_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .i_clk  (CLK),
      .i_cs   (w_cs[g]),
      .i_we   (w_we[g]),
      .i_addr (w_addr[g]),
      .i_wmask(w_wmask[g]),
      .i_wdata(w_wdata[g]),
      .o_rdata(w_rdata[g])
    );
  end

  logic                  r_a_v1, r_h_v1, r_a_rvalid, r_h_rvalid;
  logic [BANK_BITS-1:0]  r_a_bank1, r_h_bank1;
  logic [LANE_BITS-1:0]  r_h_lane1;
  vec_t                  r_a_rdata;
  logic [ELEM_WIDTH-1:0] r_h_rdata;
  logic [15:0]           r_conflict_cnt;

  // Stage 1 is the bank read register; this block tracks its valid and routing.
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      r_a_v1 <= 1'b0; r_h_v1 <= 1'b0; r_a_rvalid <= 1'b0; r_h_rvalid <= 1'b0;
      r_a_bank1 <= '0; r_h_bank1 <= '0; r_h_lane1 <= '0;
      r_a_rdata <= '0; r_h_rdata <= '0; r_conflict_cnt <= '0;
    end else if (SYNC_RST) begin
      r_a_v1 <= 1'b0; r_h_v1 <= 1'b0; r_a_rvalid <= 1'b0; r_h_rvalid <= 1'b0;
      r_a_bank1 <= '0; r_h_bank1 <= '0; r_h_lane1 <= '0;
      r_a_rdata <= '0; r_h_rdata <= '0; r_conflict_cnt <= '0;
    end else if (EN) begin
      r_a_v1     <= w_a_go & ~bus.a_we;
      r_h_v1     <= w_h_go & ~bus.h_we;
      r_a_bank1  <= w_a_bank;
      r_h_bank1  <= w_h_bank;
      r_h_lane1  <= w_h_lane;
      r_a_rvalid <= r_a_v1;
      r_h_rvalid <= r_h_v1;
      if (r_a_v1) r_a_rdata <= w_rdata[r_a_bank1];
      if (r_h_v1) r_h_rdata <= w_rdata[r_h_bank1][r_h_lane1];
      if (bus.h_req && bus.a_req && w_same_bank && (r_conflict_cnt != 16'hFFFF))
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign bus.a_gnt        = w_a_gnt;
  assign bus.h_gnt        = w_h_gnt;
  assign bus.a_rvalid     = r_a_rvalid;
  assign bus.h_rvalid     = r_h_rvalid;
  assign bus.a_rdata      = r_a_rdata;
  assign bus.h_rdata      = r_h_rdata;
  assign bus.conflict_cnt = r_conflict_cnt;
endmodule

// File: tb/tb_banked_unified_buffer.sv
// Directed bench for banked_unified_buffer with a shadow memory and read scoreboards.
module tb_banked_unified_buffer;
  import ub_pkg::*;

  localparam int SA  = 16;
  localparam int EW  = 8;
  localparam int AW  = 4;
  localparam int NB  = 8;
  localparam int BB  = 3;
  localparam int LB  = 4;
  localparam int VW  = SA * EW;
  localparam int AAW = AW + BB;
  localparam int HAW = AW + BB + LB;

  logic clk = 1'b0;
  logic async_rst, sync_rst, en;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  banked_unified_buffer_if #(.SA_LENGTH(SA), .ELEM_WIDTH(EW), .ADDR_WIDTH(AW), .NO_BANKS(NB)) bus ();

  banked_unified_buffer #(.SA_LENGTH(SA), .ELEM_WIDTH(EW), .ADDR_WIDTH(AW), .NO_BANKS(NB)) dut (
    .CLK      (clk),
    .ASYNC_RST(async_rst),
    .SYNC_RST (sync_rst),
    .EN       (en),
    .bus      (bus)
  );

  logic [VW-1:0] model [NB][2**AW];
  logic [VW-1:0] exp_a_q [$];
  int            exp_a_t [$];
  logic [EW-1:0] exp_h_q [$];
  int            exp_h_t [$];
  int            en_cyc  = 0;
  logic          last_en = 1'b0;

  always @(posedge clk) begin
    last_en = en;
    if (en) en_cyc++;
  end

  // Read scoreboard: each expected read carries the enabled cycle it must appear in.
  always @(negedge clk) begin
    if (last_en && !async_rst) begin
      if (exp_a_t.size() > 0 && exp_a_t[0] == en_cyc) begin
        tests++;
        assert (bus.a_rvalid === 1'b1 && bus.a_rdata === exp_a_q[0]) else begin
          fails++;
          $error("FAIL a_read obs=%b/%h exp=1/%h", bus.a_rvalid, bus.a_rdata, exp_a_q[0]);
        end
        void'(exp_a_q.pop_front());
        void'(exp_a_t.pop_front());
      end else begin
        tests++;
        assert (bus.a_rvalid === 1'b0) else begin
          fails++;
          $error("FAIL a_rvalid_idle obs=%b exp=0", bus.a_rvalid);
        end
      end
      if (exp_h_t.size() > 0 && exp_h_t[0] == en_cyc) begin
        tests++;
        assert (bus.h_rvalid === 1'b1 && bus.h_rdata === exp_h_q[0]) else begin
          fails++;
          $error("FAIL h_read obs=%b/%h exp=1/%h", bus.h_rvalid, bus.h_rdata, exp_h_q[0]);
        end
        void'(exp_h_q.pop_front());
        void'(exp_h_t.pop_front());
      end else begin
        tests++;
        assert (bus.h_rvalid === 1'b0) else begin
          fails++;
          $error("FAIL h_rvalid_idle obs=%b exp=0", bus.h_rvalid);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_gnt();
    return en & ~sync_rst & ~async_rst;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < SA; i++) r[i*EW +: EW] = EW'($urandom_range(0, 255));
    return r;
  endfunction

  function automatic logic [AAW-1:0] a_adr(input int word, input int bank);
    return AAW'((word << BB) | bank);
  endfunction

  function automatic logic [HAW-1:0] h_adr(input int word, input int bank, input int lane);
    return HAW'((word << (BB + LB)) | (bank << LB) | lane);
  endfunction

  task automatic model_awrite(input int word, input int bank, input logic [SA-1:0] mask,
                              input logic [VW-1:0] data);
    for (int i = 0; i < SA; i++)
      if (mask[i]) model[bank][word][i*EW +: EW] = data[i*EW +: EW];
  endtask

  task automatic a_write(input int word, input int bank, input logic [SA-1:0] mask,
                         input logic [VW-1:0] data);
    logic g;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = a_adr(word, bank);
    bus.a_wmask = mask; bus.a_wdata = data;
    #1;
    g = exp_gnt();
    chk("a_gnt_wr", 32'(bus.a_gnt), 32'(g));
    if (g) model_awrite(word, bank, mask, data);
    tick();
    bus.a_req = 1'b0; bus.a_we = 1'b0;
  endtask

  task automatic a_read(input int word, input int bank);
    logic g;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = a_adr(word, bank);
    #1;
    g = exp_gnt();
    chk("a_gnt_rd", 32'(bus.a_gnt), 32'(g));
    if (g) begin
      exp_a_q.push_back(model[bank][word]);
      exp_a_t.push_back(en_cyc + 2);
    end
    tick();
    bus.a_req = 1'b0;
  endtask

  task automatic h_write(input int word, input int bank, input int lane, input logic [EW-1:0] d);
    logic g;
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = h_adr(word, bank, lane); bus.h_wdata = d;
    #1;
    g = exp_gnt();
    chk("h_gnt_wr", 32'(bus.h_gnt), 32'(g));
    if (g) model[bank][word][lane*EW +: EW] = d;
    tick();
    bus.h_req = 1'b0; bus.h_we = 1'b0;
  endtask

  task automatic h_read(input int word, input int bank, input int lane);
    logic g;
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = h_adr(word, bank, lane);
    #1;
    g = exp_gnt();
    chk("h_gnt_rd", 32'(bus.h_gnt), 32'(g));
    if (g) begin
      exp_h_q.push_back(model[bank][word][lane*EW +: EW]);
      exp_h_t.push_back(en_cyc + 2);
    end
    tick();
    bus.h_req = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] v;
    bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wmask = '0; bus.a_wdata = '0;
    en = 1'b1; sync_rst = 1'b0; async_rst = 1'b1;
    #1;
    chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    chk("rst_h_rvalid", 32'(bus.h_rvalid), 32'd0);
    chk("rst_cnt", 32'(bus.conflict_cnt), 32'd0);
    chk("rst_h_rdata", 32'(bus.h_rdata), 32'd0);
    chk("rst_a_rdata_zero", 32'(bus.a_rdata == '0), 32'd1);
    chk("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 async_rst = 1'b0;
    #1 chk("a_gnt_idle", 32'(bus.a_gnt), 32'd1);
    tick();

    // Lane-index pattern, read back two enabled cycles later
    for (int i = 0; i < SA; i++) v[i*EW +: EW] = EW'(i);
    a_write(5, 3, '1, v);
    a_read(5, 3);
    repeat (3) tick();

    // Host lane write then wide readback; other lanes keep the pattern
    h_write(5, 3, 7, 8'hAB);
    a_read(5, 3);
    h_read(5, 3, 7);
    h_read(5, 3, 6);
    repeat (3) tick();

    // Partial mask write
    a_write(9, 2, '1, rnd_vec());
    a_write(9, 2, 16'h000F, rnd_vec());
    a_read(9, 2);
    repeat (3) tick();

    // Host and array on different banks in the same cycle
    a_write(1, 1, '1, rnd_vec());
    a_write(3, 2, '1, rnd_vec());
    v = rnd_vec();
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = h_adr(1, 1, 4); bus.h_wdata = 8'h77;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = a_adr(3, 6); bus.a_wmask = '1; bus.a_wdata = v;
    #1;
    chk("par_h_gnt", 32'(bus.h_gnt), 32'd1);
    chk("par_a_gnt", 32'(bus.a_gnt), 32'd1);
    model[1][1][4*EW +: EW] = 8'h77;
    model_awrite(3, 6, '1, v);
    tick();
    bus.h_we = 1'b0; bus.a_we = 1'b0;
    bus.h_addr = h_adr(3, 2, 5); bus.a_addr = a_adr(1, 1);
    #1;
    chk("par_rd_h_gnt", 32'(bus.h_gnt), 32'd1);
    exp_h_q.push_back(model[2][3][5*EW +: EW]); exp_h_t.push_back(en_cyc + 2);
    exp_a_q.push_back(model[1][1]);            exp_a_t.push_back(en_cyc + 2);
    tick();
    bus.h_req = 1'b0; bus.a_req = 1'b0;
    a_read(3, 6);
    repeat (3) tick();
    chk("cnt_before_conflict", 32'(bus.conflict_cnt), 32'd0);

    // Same-bank conflict: host stalls for three cycles, then wins
    a_write(0, 4, '1, rnd_vec());
    a_write(1, 4, '1, rnd_vec());
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = h_adr(1, 4, 2); bus.h_wdata = 8'h5C;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = a_adr(0, 4);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("conf_h_gnt", 32'(bus.h_gnt), 32'd0);
      chk("conf_a_gnt", 32'(bus.a_gnt), 32'd1);
      exp_a_q.push_back(model[4][0]); exp_a_t.push_back(en_cyc + 2);
      tick();
    end
    chk("conf_cnt3", 32'(bus.conflict_cnt), 32'd3);
    bus.a_req = 1'b0;
    #1 chk("conf_h_gnt4", 32'(bus.h_gnt), 32'd1);
    model[4][1][2*EW +: EW] = 8'h5C;
    tick();
    bus.h_req = 1'b0; bus.h_we = 1'b0;
    h_read(1, 4, 2);
    repeat (3) tick();
    chk("conf_cnt_hold", 32'(bus.conflict_cnt), 32'd3);

    // Async reset one cycle after a granted host read drops it
    h_read(5, 3, 7);
    async_rst = 1'b1;
    #1;
    chk("arst_h_rvalid", 32'(bus.h_rvalid), 32'd0);
    chk("arst_cnt", 32'(bus.conflict_cnt), 32'd0);
    chk("arst_h_rdata", 32'(bus.h_rdata), 32'd0);
    exp_h_q.delete(); exp_h_t.delete(); exp_a_q.delete(); exp_a_t.delete();
    #2 async_rst = 1'b0;
    tick();
    repeat (3) tick();
    h_read(5, 3, 7);
    repeat (3) tick();

    // EN low freezes pipeline, counter and rdata and blocks writes
    h_read(9, 2, 1);
    en = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = a_adr(9, 2); bus.a_wmask = '1; bus.a_wdata = '1;
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = h_adr(9, 2, 0);
    #1 chk("frz_a_gnt", 32'(bus.a_gnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_h_rvalid", 32'(bus.h_rvalid), 32'd0);
      chk("frz_h_rdata", 32'(bus.h_rdata), 32'hAB);
      chk("frz_cnt", 32'(bus.conflict_cnt), 32'd0);
    end
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.h_req = 1'b0;
    en = 1'b1;
    repeat (3) tick();
    a_read(9, 2);
    repeat (3) tick();

    // Sync reset with EN low: clears counter, drops in-flight read, blocks writes
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = h_adr(0, 6, 0);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = a_adr(0, 6); bus.a_wmask = '0;
    repeat (2) tick();
    chk("srst_cnt_pre", 32'(bus.conflict_cnt), 32'd2);
    bus.h_req = 1'b0; bus.a_req = 1'b0; bus.a_we = 1'b0;
    a_read(5, 3);
    en = 1'b0; sync_rst = 1'b1;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = a_adr(5, 3); bus.a_wmask = '1; bus.a_wdata = '1;
    #1 chk("srst_a_gnt", 32'(bus.a_gnt), 32'd0);
    tick();
    chk("srst_cnt", 32'(bus.conflict_cnt), 32'd0);
    chk("srst_a_rdata", 32'(bus.a_rdata == '0), 32'd1);
    exp_a_q.delete(); exp_a_t.delete();
    bus.a_req = 1'b0; bus.a_we = 1'b0;
    sync_rst = 1'b0; en = 1'b1;
    repeat (3) tick();
    a_read(5, 3);
    repeat (3) tick();

    // Counter saturation
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = h_adr(0, 0, 0);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = a_adr(0, 0); bus.a_wmask = '0;
    #1 chk("sat_h_gnt", 32'(bus.h_gnt), 32'd0);
    repeat (65534) @(posedge clk);
    #1 chk("sat_fffe", 32'(bus.conflict_cnt), 32'hFFFE);
    tick();
    chk("sat_ffff", 32'(bus.conflict_cnt), 32'hFFFF);
    repeat (5) tick();
    chk("sat_hold", 32'(bus.conflict_cnt), 32'hFFFF);
    bus.h_req = 1'b0; bus.a_req = 1'b0; bus.a_we = 1'b0;
    repeat (4) tick();
    chk("drain_a", 32'(exp_a_q.size()), 32'd0);
    chk("drain_h", 32'(exp_h_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/banked_unified_buffer.md
BANKED_UNIFIED_BUFFER -- requirements
Module: banked_unified_buffer

Interface
REQ-001 Parameter SA_LENGTH, default 256, is the number of lanes in one wide word (power of two).
REQ-002 Parameter ELEM_WIDTH, default 8, is the bits per lane element (8 or 16).
REQ-003 Parameter ADDR_WIDTH, default 10, is the word-address bits per bank.
REQ-004 Parameter NO_BANKS, default 8, is the bank count (power of two); BANK_BITS=$clog2(NO_BANKS), LANE_BITS=$clog2(SA_LENGTH).
REQ-005 Port CLK  in  1  is the single clock, rising edge.
REQ-006 Port ASYNC_RST  in  1  is the asynchronous, active-high reset.
REQ-007 Port SYNC_RST  in  1  is the synchronous clear, active-high.
REQ-008 Port EN  in  1  is the global enable; low freezes all state.
REQ-009 Ports h_req/h_we  in  1/1  are the host request and write select (1=write, 0=read).
REQ-010 Port h_addr  in  ADDR_WIDTH+BANK_BITS+LANE_BITS  is {word, bank, lane}.
REQ-011 Ports h_wdata in ELEM_WIDTH and h_rdata out ELEM_WIDTH carry host data; h_gnt out 1 accepts; h_rvalid out 1 qualifies h_rdata.
REQ-012 Ports a_req/a_we  in  1/1  are the array-side request and write select.
REQ-013 Port a_addr  in  ADDR_WIDTH+BANK_BITS  is {word, bank}; a_wmask  in  SA_LENGTH  is the per-lane write enable.
REQ-014 Ports a_wdata in [SA_LENGTH][ELEM_WIDTH] and a_rdata out [SA_LENGTH][ELEM_WIDTH] carry wide data; a_gnt out 1; a_rvalid out 1.
REQ-015 Port conflict_cnt  out  16  is the saturating count of bank-conflict stall cycles.

Function
REQ-016 a_gnt SHALL equal EN & !SYNC_RST & !ASYNC_RST (array port never stalls).
REQ-017 h_gnt SHALL equal a_gnt & !(a_req & bank(a_addr)==bank(h_addr)); host loses every same-bank conflict.
REQ-018 Granted write SHALL update memory at the grant-cycle edge; array writes only lanes with a_wmask[i]=1, host writes only lane h_addr.lane.
REQ-019 Granted read SHALL give rvalid=1 and data exactly 2 EN-cycles after grant (stage 1: bank read register; stage 2: output register/lane select).
REQ-020 rvalid SHALL be 0 for cycles with no granted read; rdata holds last value when rvalid=0.
REQ-021 Read granted in the cycle after a write to the same address SHALL return the new data; array and host ports on different banks in the same cycle SHALL operate independently.
REQ-022 Ungranted requests (h_req & !h_gnt) SHALL have no effect; requester holds the request until granted.
REQ-023 conflict_cnt SHALL increment each EN cycle with h_req & a_req & equal banks & !SYNC_RST, saturating at 16'hFFFF.
REQ-024 EN=0 SHALL freeze read pipelines, rvalid, rdata, counter; no memory writes.
REQ-025 Address fields cover the full space; no out-of-range case exists.

Reset
REQ-026 ASYNC_RST=1 SHALL immediately clear h_rvalid, a_rvalid, h_rdata, a_rdata, conflict_cnt and pipeline valids to 0.
REQ-027 SYNC_RST=1 at a rising edge SHALL clear the same registers, regardless of EN, and suppress writes.
REQ-028 Reads in flight at reset SHALL be dropped (no rvalid afterwards); memory contents SHALL not be reset.

Structure
REQ-029 Package ub_pkg SHALL hold ELEM_WIDTH default, derived width functions and the lane-vector typedef.
REQ-030 Sub-module ub_bank SHALL implement one bank: single port, per-lane write enable, registered wide read; instantiated NO_BANKS times.

Verification
REQ-031 Array write a_addr={5,3}, mask all ones, lane i=i; array read same -> a_rvalid 2 cycles later, a_rdata[i]=i.
REQ-032 Host write word 5/bank 3/lane 7 = 0xAB, then array read {5,3} -> lane 7=0xAB, other lanes unchanged.
REQ-033 Array write mask 0x0F over bank 2 -> only lanes 0-3 change on readback.
REQ-034 h_req and a_req both on bank 4 for 3 cycles -> h_gnt=0 for 3 cycles, conflict_cnt=3; host granted on 4th cycle.
REQ-035 Host read granted, ASYNC_RST pulses next cycle -> h_rvalid never asserts; conflict_cnt=0.
REQ-036 Preload conflict_cnt near 16'hFFFF through 65540 conflict cycles -> holds 16'hFFFF.
